// File: rtl/divider_arbiter.sv
// Round-robin arbiter that shares one serial divider among N_REQ requesters.
// Divisor-zero jobs skip the divider and complete with an all-ones quotient.
module divider_arbiter #(
    parameter int N_REQ   = 4,
    parameter int bw_Dsor = 4,
    parameter int bw_Dend = 7,
    parameter int bw_id   = 2
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [N_REQ*bw_Dsor-1:0] ReqDsor,
    input  logic [N_REQ*bw_Dend-1:0] ReqDend,
    output logic [N_REQ-1:0]         Ack,
    output logic                     ResValid,
    output logic [bw_Dend-1:0]       ResQuo,
    output logic [bw_id-1:0]         ResId,
    output logic                     ResDz,
    output logic                     Busy,
    output logic                     DivStart,
    output logic [bw_Dsor-1:0]       DivDsor,
    output logic [bw_Dend-1:0]       DivDend,
    input  logic [bw_Dend-1:0]       DivQuo,
    input  logic                     DivEnd,
    input  logic                     DivBusy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ZERO  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [bw_id-1:0]   last_id, last_id_nxt;
    logic [bw_id-1:0]   cur_id, cur_id_nxt;
    logic [bw_id-1:0]   rr_idx, grant_id;
    logic               grant_valid;
    logic [bw_Dsor-1:0] grant_dsor, dsor_nxt;
    logic [bw_Dend-1:0] grant_dend, dend_nxt;
    logic [N_REQ-1:0]   ack_nxt;
    logic               start_nxt, valid_nxt, dz_nxt;
    logic [bw_Dend-1:0] quo_nxt;
    logic [bw_id-1:0]   res_id_nxt;

    // Scan offsets from farthest to nearest so the nearest set Req after last_id wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        rr_idx      = '0;
        grant_dsor  = '0;
        grant_dend  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            rr_idx = bw_id'((int'(last_id) + 1 + i) % N_REQ);
            if (Req[rr_idx]) begin
                grant_valid = 1'b1;
                grant_id    = rr_idx;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (bw_id'(k) == grant_id) begin
                grant_dsor = ReqDsor[k*bw_Dsor +: bw_Dsor];
                grant_dend = ReqDend[k*bw_Dend +: bw_Dend];
            end
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        last_id_nxt = last_id;
        cur_id_nxt  = cur_id;
        dsor_nxt    = DivDsor;
        dend_nxt    = DivDend;
        ack_nxt     = '0;
        start_nxt   = 1'b0;
        valid_nxt   = 1'b0;
        quo_nxt     = ResQuo;
        res_id_nxt  = ResId;
        dz_nxt      = ResDz;
        case (state)
            S_IDLE: begin
                if (grant_valid && !DivBusy) begin
                    cur_id_nxt = grant_id;
                    dsor_nxt   = grant_dsor;
                    dend_nxt   = grant_dend;
                    ack_nxt    = N_REQ'(1) << grant_id;
                    start_nxt  = (grant_dsor != '0);
                    state_nxt  = (grant_dsor == '0) ? S_ZERO : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_ZERO: begin
                quo_nxt    = '1;
                dz_nxt     = 1'b1;
                res_id_nxt = cur_id;
                valid_nxt  = 1'b1;
                state_nxt  = S_DONE;
            end
            S_WAIT: begin
                if (DivEnd) begin
                    quo_nxt    = DivQuo;
                    dz_nxt     = 1'b0;
                    res_id_nxt = cur_id;
                    valid_nxt  = 1'b1;
                    state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                last_id_nxt = cur_id;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            last_id  <= bw_id'(N_REQ - 1);
            cur_id   <= '0;
            Ack      <= '0;
            ResValid <= 1'b0;
            ResQuo   <= '0;
            ResId    <= '0;
            ResDz    <= 1'b0;
            Busy     <= 1'b0;
            DivStart <= 1'b0;
            DivDsor  <= '0;
            DivDend  <= '0;
        end else begin
            state    <= state_nxt;
            last_id  <= last_id_nxt;
            cur_id   <= cur_id_nxt;
            Ack      <= ack_nxt;
            ResValid <= valid_nxt;
            ResQuo   <= quo_nxt;
            ResId    <= res_id_nxt;
            ResDz    <= dz_nxt;
            Busy     <= (state_nxt != S_IDLE);
            DivStart <= start_nxt;
            DivDsor  <= dsor_nxt;
            DivDend  <= dend_nxt;
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a behavioural serial divider model.
// Expected results are queued at stimulus time and popped when ResValid fires.
module tb_divider_arbiter;

    localparam int N_REQ = 4;

    typedef struct {
        logic [1:0] id;
        logic [6:0] quo;
        logic       dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  Req;
    logic [15:0] ReqDsor;
    logic [27:0] ReqDend;
    logic [3:0]  Ack;
    logic        ResValid, ResDz, Busy, DivStart, DivEnd, DivBusy;
    logic [6:0]  ResQuo, DivDend, DivQuo;
    logic [1:0]  ResId;
    logic [3:0]  DivDsor;

    logic        model_en, m_busy, m_end, tb_busy, tb_end;
    logic [6:0]  m_quo;
    int          m_cnt, m_end_cyc, cyc, start_cnt;
    int          total, bad;
    exp_t        sb[$];

    always #5 clk = ~clk;

    assign DivBusy = m_busy | tb_busy;
    assign DivEnd  = m_end | tb_end;
    assign DivQuo  = m_quo;

    divider_arbiter #(.N_REQ(4), .bw_Dsor(4), .bw_Dend(7), .bw_id(2)) dut (
        .Clock(clk), .Reset(Reset), .Req(Req), .ReqDsor(ReqDsor), .ReqDend(ReqDend),
        .Ack(Ack), .ResValid(ResValid), .ResQuo(ResQuo), .ResId(ResId), .ResDz(ResDz),
        .Busy(Busy), .DivStart(DivStart), .DivDsor(DivDsor), .DivDend(DivDend),
        .DivQuo(DivQuo), .DivEnd(DivEnd), .DivBusy(DivBusy)
    );

    always @(posedge clk) cyc++;

    // Divider model: End pulses 2..5 cycles after Start; Busy clears after End.
    always @(negedge clk) begin
        if (DivStart) start_cnt++;
        if (m_end) begin
            m_end  = 1'b0;
            m_busy = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_end     = 1'b1;
                m_end_cyc = cyc;
            end
        end else if (model_en && DivStart) begin
            m_busy = 1'b1;
            m_cnt  = $urandom_range(2, 5);
            m_quo  = (DivDsor == 0) ? 7'h7F : DivDend / 7'(DivDsor);
        end
    end

    always @(negedge clk) begin
        if (ResValid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: ResValid with id=%0d quo=%0d, none expected", ResId, ResQuo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ResId !== e.id || ResQuo !== e.quo || ResDz !== e.dz) begin
                    bad++;
                    $display("FAIL sb_result: got id=%0d quo=%0d dz=%b want id=%0d quo=%0d dz=%b",
                             ResId, ResQuo, ResDz, e.id, e.quo, e.dz);
                end
            end
        end
    end

    task automatic wait_result(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = ResValid;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: no ResValid within 40 cycles, want one", name);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({Ack, ResValid, ResQuo, ResId, ResDz, Busy, DivStart, DivDsor, DivDend} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ack=%b valid=%b quo=%0d busy=%b start=%b, want all 0",
                     Ack, ResValid, ResQuo, Busy, DivStart);
        end
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (Busy !== 1'b0 || Ack !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b ack=%b, want 0 0", Busy, Ack);
        end
    endtask

    task automatic test_single();
        ReqDsor[4 +: 4] = 4'd3;
        ReqDend[7 +: 7] = 7'd100;
        Req = 4'b0010;
        sb.push_back('{id: 2'd1, quo: 7'd33, dz: 1'b0});
        @(negedge clk);
        total++;
        if (Ack !== 4'b0010 || DivStart !== 1'b1 || Busy !== 1'b1 || DivDsor !== 4'd3 || DivDend !== 7'd100) begin
            bad++;
            $display("FAIL single_issue: got ack=%b start=%b busy=%b dsor=%0d dend=%0d, want 0010 1 1 3 100",
                     Ack, DivStart, Busy, DivDsor, DivDend);
        end
        Req = 4'b0;
        @(negedge clk);
        total++;
        if (Ack !== 4'b0 || DivStart !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse: got ack=%b start=%b, want 0000 0", Ack, DivStart);
        end
        wait_result("single");
        total++;
        if (cyc !== m_end_cyc + 1 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: got valid cycle=%0d busy=%b, want cycle=%0d busy=1",
                     cyc, Busy, m_end_cyc + 1);
        end
        @(negedge clk);
        total++;
        if (Busy !== 1'b0 || ResValid !== 1'b0) begin
            bad++;
            $display("FAIL single_release: got busy=%b valid=%b, want 0 0", Busy, ResValid);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int n = 0, done = 0;
        bit active = 0;
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            ReqDsor[k*4 +: 4] = 4'(k + 2);
            ReqDend[k*7 +: 7] = 7'(13 * k + 50);
        end
        for (int j = 0; j < 5; j++)
            sb.push_back('{id: 2'(order[j]), quo: 7'((13 * order[j] + 50) / (order[j] + 2)), dz: 1'b0});
        Req = 4'b1111;
        for (int c = 0; c < 300 && done < 5; c++) begin
            @(negedge clk);
            if (Ack !== 4'b0) begin
                total++;
                if (n >= 5 || active || Ack !== 4'(1 << order[n])) begin
                    bad++;
                    $display("FAIL rr_grant: got ack=%b active=%b grant#=%0d, want ack=%b with no job active",
                             Ack, active, n, 4'(1 << order[n % 5]));
                end
                active = 1;
                n++;
                if (n == 5) Req = 4'b0;
            end
            if (active) begin
                total++;
                if (Busy !== 1'b1) begin
                    bad++;
                    $display("FAIL rr_busy: got busy=%b during job %0d, want 1", Busy, n - 1);
                end
            end
            if (ResValid) begin
                active = 0;
                done++;
            end
        end
        Req = 4'b0;
        total++;
        if (done != 5) begin
            bad++;
            $display("FAIL rr_count: got %0d results, want 5", done);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int sc = start_cnt;
        ReqDsor[8 +: 4] = 4'd0;
        ReqDend[14 +: 7] = 7'd55;
        Req = 4'b0100;
        sb.push_back('{id: 2'd2, quo: 7'h7F, dz: 1'b1});
        @(negedge clk);
        total++;
        if (Ack !== 4'b0100 || DivStart !== 1'b0 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL dz_ack: got ack=%b start=%b busy=%b, want 0100 0 1", Ack, DivStart, Busy);
        end
        Req = 4'b0;
        @(negedge clk);
        total++;
        if (ResValid !== 1'b1 || ResDz !== 1'b1) begin
            bad++;
            $display("FAIL dz_result: got valid=%b dz=%b in cycle 2, want 1 1", ResValid, ResDz);
        end
        repeat (2) @(negedge clk);
        total++;
        if (start_cnt != sc || ResValid !== 1'b0) begin
            bad++;
            $display("FAIL dz_nostart: got %0d DivStart pulses valid=%b, want 0 0", start_cnt - sc, ResValid);
        end
    endtask

    task automatic test_reset_abort();
        bit seen = 0;
        model_en = 1'b0;
        ReqDsor[0 +: 4] = 4'd5;
        ReqDend[0 +: 7] = 7'd77;
        Req = 4'b0001;
        @(negedge clk);
        total++;
        if (Ack !== 4'b0001 || DivStart !== 1'b1) begin
            bad++;
            $display("FAIL abort_issue: got ack=%b start=%b, want 0001 1", Ack, DivStart);
        end
        Req = 4'b0;
        tb_busy = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        Req = 4'b0001;
        ReqDsor[0 +: 4] = 4'd6;
        ReqDend[0 +: 7] = 7'd100;
        @(negedge clk);
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (Ack !== 4'b0 || ResValid !== 1'b0) begin
                bad++;
                $display("FAIL abort_hold: got ack=%b valid=%b at cycle %0d of DivBusy, want 0000 0",
                         Ack, ResValid, c);
            end
        end
        tb_busy = 1'b0;
        model_en = 1'b1;
        sb.push_back('{id: 2'd0, quo: 7'd16, dz: 1'b0});
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = (Ack !== 4'b0);
        end
        total++;
        if (!seen || Ack !== 4'b0001) begin
            bad++;
            $display("FAIL abort_regrant: got ack=%b, want 0001 after DivBusy fell", Ack);
        end
        Req = 4'b0;
        wait_result("abort");
        @(negedge clk);
    endtask

    task automatic test_spurious_end();
        Req = 4'b0;
        @(negedge clk);
        tb_end = 1'b1;
        @(negedge clk);
        tb_end = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (ResValid !== 1'b0 || Busy !== 1'b0 || Ack !== 4'b0) begin
                bad++;
                $display("FAIL spurious_end: got valid=%b busy=%b ack=%b, want 0 0 0000", ResValid, Busy, Ack);
            end
        end
    endtask

    task automatic test_sweep();
        for (int dsor = 1; dsor < 16; dsor++) begin
            for (int dend = 0; dend < 128; dend++) begin
                int  k = $urandom_range(0, N_REQ - 1);
                bit  seen = 0;
                ReqDsor = 16'($urandom);
                ReqDend = 28'($urandom);
                ReqDsor[k*4 +: 4] = 4'(dsor);
                ReqDend[k*7 +: 7] = 7'(dend);
                Req = 4'(1 << k);
                sb.push_back('{id: 2'(k), quo: 7'(dend / dsor), dz: 1'b0});
                for (int c = 0; c < 10 && !seen; c++) begin
                    @(negedge clk);
                    seen = (Ack !== 4'b0);
                end
                total++;
                if (!seen || Ack !== 4'(1 << k)) begin
                    bad++;
                    $display("FAIL sweep_ack: got ack=%b for %0d/%0d, want %b", Ack, dend, dsor, 4'(1 << k));
                end
                Req = 4'b0;
                ReqDsor = 16'($urandom);
                ReqDend = 28'($urandom);
                wait_result("sweep");
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; start_cnt = 0;
        m_busy = 0; m_end = 0; m_cnt = 0; m_quo = '0; m_end_cyc = 0;
        model_en = 1'b1; tb_busy = 1'b0; tb_end = 1'b0;
        Reset = 1'b1; Req = '0; ReqDsor = '0; ReqDend = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_div_zero();
        test_reset_abort();
        test_spurious_end();
        test_sweep();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d results outstanding, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
